// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the 4-entry physical register file (with write-back
// bypass), tracks in-flight producers in a per-register scoreboard, stalls on
// RAW/WAW hazards, and drives a registered valid/ready handshake to execute.
module operand_fetch #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rs_a,
  input  logic [1:0]        in_rs_b,
  input  logic [1:0]        in_rd,
  input  logic              in_rd_we,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        out_rd,
  output logic              out_rd_we,
  output logic [OP_W-1:0]   out_op,
  input  logic              wb_valid,
  input  logic [1:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data
);

  localparam int NREG = 4;

  logic [NREG-1:0][DATA_W-1:0] rf_q, rf_d;
  logic [NREG-1:0]             pend_q, pend_d;

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        rd_q, rd_d;
  logic              we_q, we_d;
  logic [OP_W-1:0]   op_q, op_d;

  logic              wb_hit_a, wb_hit_b, wb_hit_d;
  logic              haz_a, haz_b, haz_d;
  logic              accept;
  logic [DATA_W-1:0] opnd_a, opnd_b;

  // Hazard detection; a write-back landing this cycle resolves the pending
  // producer, so it also lifts the stall and feeds the bypass mux.
  always_comb begin
    wb_hit_a = wb_valid && (wb_rd == in_rs_a);
    wb_hit_b = wb_valid && (wb_rd == in_rs_b);
    wb_hit_d = wb_valid && (wb_rd == in_rd);
    haz_a    = pend_q[in_rs_a] && !wb_hit_a;
    haz_b    = pend_q[in_rs_b] && !wb_hit_b;
    haz_d    = in_rd_we && pend_q[in_rd] && !wb_hit_d;
    in_ready = (!vld_q || out_ready) && !(haz_a || haz_b || haz_d);
    accept   = in_valid && in_ready;
    opnd_a   = wb_hit_a ? wb_data : rf_q[in_rs_a];
    opnd_b   = wb_hit_b ? wb_data : rf_q[in_rs_b];
  end

  // Regfile write and scoreboard update; a new producer's set beats the
  // clear from an older producer's write-back on the same index.
  always_comb begin
    rf_d   = rf_q;
    pend_d = pend_q;
    if (wb_valid) begin
      rf_d[wb_rd]   = wb_data;
      pend_d[wb_rd] = 1'b0;
    end
    if (accept && in_rd_we) pend_d[in_rd] = 1'b1;
  end

  // Output register: load on accept, drop valid after a transfer, else hold.
  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    rd_d  = rd_q;
    we_d  = we_q;
    op_d  = op_q;
    if (accept) begin
      vld_d = 1'b1;
      a_d   = opnd_a;
      b_d   = opnd_b;
      rd_d  = in_rd;
      we_d  = in_rd_we;
      op_d  = in_op;
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  // State registers; reset clears regs, scoreboard and any in-flight output.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q   <= '0;
      pend_q <= '0;
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      we_q   <= 1'b0;
      op_q   <= '0;
    end else begin
      rf_q   <= rf_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      rd_q   <= rd_d;
      we_q   <= we_d;
      op_q   <= op_d;
    end
  end

  assign out_valid = vld_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rd    = rd_q;
  assign out_rd_we = we_q;
  assign out_op    = op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: scenario tasks push expected output beats into a
// queue at accept time; a negedge monitor pops and compares on each transfer.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [1:0] in_rs_a, in_rs_b, in_rd;
  logic       in_rd_we;
  logic [3:0] in_op;
  logic       out_valid, out_ready;
  logic [7:0] out_a, out_b;
  logic [1:0] out_rd;
  logic       out_rd_we;
  logic [3:0] out_op;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] rd;
    logic       we;
    logic [3:0] op;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(8), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_op(out_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Transfer monitor: every handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beat_t got, e;
      got = {out_a, out_b, out_rd, out_rd_we, out_op};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL xfer_unexpected: got %h, required no transfer", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          $display("FAIL xfer_beat: got a=%h b=%h rd=%0d we=%b op=%h, required a=%h b=%h rd=%0d we=%b op=%h",
                   got.a, got.b, got.rd, got.we, got.op, e.a, e.b, e.rd, e.we, e.op);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                       input logic we, input logic [3:0] op);
    in_valid = 1'b1; in_rs_a = ra; in_rs_b = rb; in_rd = rd; in_rd_we = we; in_op = op;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_rs_a = 0; in_rs_b = 0; in_rd = 0; in_rd_we = 0; in_op = 0;
    // write-back during reset must be ignored
    wb_valid = 1'b1; wb_rd = 2'd2; wb_data = 8'hAA;
    step(); settle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", out_valid);
    else n_pass++;
    n_total++;
    if ({out_a, out_b, out_rd, out_rd_we, out_op} !== 23'h0)
      $display("FAIL reset_outs: got %h, required 0", {out_a, out_b, out_rd, out_rd_we, out_op});
    else n_pass++;
    step();
    reset = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic test_basic_issue();
    issue(2'd1, 2'd2, 2'd0, 1'b0, 4'h3);
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h00, 8'h00, 2'd0, 1'b0, 4'h3});
    step(); in_valid = 1'b0;
    settle();
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: got out_valid=%b, required 1", out_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_wb_then_read();
    wb_valid = 1'b1; wb_rd = 2'd2; wb_data = 8'h5A;
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL wbread_ready0: got %b, required 1", in_ready);
    else n_pass++;
    step(); wb_valid = 1'b0;
    issue(2'd2, 2'd0, 2'd0, 1'b0, 4'h5);
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL wbread_ready1: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h5A, 8'h00, 2'd0, 1'b0, 4'h5});
    step(); in_valid = 1'b0;
    settle(); step();
  endtask

  task automatic test_raw_stall();
    issue(2'd0, 2'd0, 2'd3, 1'b1, 4'h1);
    settle();
    exp_q.push_back('{8'h00, 8'h00, 2'd3, 1'b1, 4'h1});
    step();
    issue(2'd3, 2'd1, 2'd0, 1'b0, 4'h2);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL raw_stall_%0d: got in_ready=%b, required 0", i, in_ready);
      else n_pass++;
      step();
    end
    wb_valid = 1'b1; wb_rd = 2'd3; wb_data = 8'h11;
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL raw_release: got in_ready=%b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h11, 8'h00, 2'd0, 1'b0, 4'h2});
    step(); wb_valid = 1'b0; in_valid = 1'b0;
    settle(); step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(2'd2, 2'd3, 2'd0, 1'b0, 4'h7);
    settle();
    exp_q.push_back('{8'h5A, 8'h11, 2'd0, 1'b0, 4'h7});
    step();
    issue(2'd3, 2'd2, 2'd0, 1'b0, 4'h8);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_total++;
      if ({out_valid, out_a, out_b, out_op} !== {1'b1, 8'h5A, 8'h11, 4'h7})
        $display("FAIL hold_stable_%0d: got v=%b a=%h b=%h op=%h, required v=1 a=5a b=11 op=7",
                 i, out_valid, out_a, out_b, out_op);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL hold_ready_%0d: got %b, required 0", i, in_ready);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL release_ready: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h11, 8'h5A, 2'd0, 1'b0, 4'h8});
    step(); in_valid = 1'b0;
    settle(); step();
  endtask

  task automatic test_set_beats_clear();
    issue(2'd0, 2'd0, 2'd1, 1'b1, 4'h9);
    settle();
    exp_q.push_back('{8'h00, 8'h00, 2'd1, 1'b1, 4'h9});
    step(); in_valid = 1'b0;
    settle(); step();
    // r1 pending: WAW is lifted only because wb r1 lands this cycle
    issue(2'd0, 2'd0, 2'd1, 1'b1, 4'hA);
    wb_valid = 1'b1; wb_rd = 2'd1; wb_data = 8'h33;
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL waw_bypass_ready: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h00, 8'h00, 2'd1, 1'b1, 4'hA});
    step(); wb_valid = 1'b0;
    issue(2'd1, 2'd1, 2'd0, 1'b0, 4'hB);
    for (int i = 0; i < 2; i++) begin
      settle();
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL set_wins_%0d: got in_ready=%b, required 0", i, in_ready);
      else n_pass++;
      step();
    end
    wb_valid = 1'b1; wb_rd = 2'd1; wb_data = 8'h44;
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL same_src_ready: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h44, 8'h44, 2'd0, 1'b0, 4'hB});
    step(); wb_valid = 1'b0; in_valid = 1'b0;
    settle(); step();
  endtask

  task automatic test_reset_midflight();
    issue(2'd0, 2'd0, 2'd1, 1'b1, 4'hC);
    settle();
    exp_q.push_back('{8'h00, 8'h00, 2'd1, 1'b1, 4'hC});
    step();
    issue(2'd0, 2'd0, 2'd2, 1'b1, 4'hD);
    settle();
    exp_q.push_back('{8'h00, 8'h00, 2'd2, 1'b1, 4'hD});
    step(); in_valid = 1'b0; out_ready = 1'b0;
    settle();
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL midflight_pre: got out_valid=%b, required 1", out_valid);
    else n_pass++;
    step();
    reset = 1'b1;
    wb_valid = 1'b1; wb_rd = 2'd0; wb_data = 8'hFF;
    exp_q.delete();
    step();
    reset = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
    settle();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL midflight_valid: got %b, required 0", out_valid);
    else n_pass++;
    step();
    // r1/r2 were pending before reset: must not stall now, and all regs read 0
    issue(2'd1, 2'd2, 2'd0, 1'b0, 4'hE);
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_ready0: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h00, 8'h00, 2'd0, 1'b0, 4'hE});
    step();
    issue(2'd3, 2'd0, 2'd0, 1'b0, 4'hF);
    settle();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_ready1: got %b, required 1", in_ready);
    else n_pass++;
    exp_q.push_back('{8'h00, 8'h00, 2'd0, 1'b0, 4'hF});
    step(); in_valid = 1'b0;
    settle(); step();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wb_then_read();
    test_raw_stall();
    test_backpressure();
    test_set_beats_clear();
    test_reset_midflight();
    settle();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
